// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding and the control-bundle values driven back into PC, IF/ID and ID/EX.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_hold;
    logic exmem_hold;
  } ctrl_t;

  // Bit order: pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold
  localparam ctrl_t CTRL_DEFAULT = 6'b110000;
  localparam ctrl_t CTRL_STALL   = 6'b000100;
  localparam ctrl_t CTRL_FREEZE  = 6'b000011;
  localparam ctrl_t CTRL_FLUSH   = 6'b101100;
  localparam ctrl_t CTRL_RESET   = 6'b001100;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Mealy pipeline hazard controller: load-use stalls, taken-branch flushes and
// memory-busy freeze. Performance counters are built only with HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  idex_hold,
  output logic                  exmem_hold,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [1:0] LU_LEFT_INIT = 2'(LU_STALL_CYCLES - 1);

  state_t     state_q, next_state, run_next;
  logic [1:0] lu_left_q, next_lu_left, run_lu_left;
  ctrl_t      ctrl, run_ctrl;
  logic       lu;

  assign lu = ex_memRead && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Decision of a RUN cycle, shared with the zero-cycle exit from MEM_WAIT
  always_comb begin
    run_ctrl    = CTRL_DEFAULT;
    run_next    = RUN;
    run_lu_left = lu_left_q;
    if (mem_busy) begin
      run_ctrl = CTRL_FREEZE;
      run_next = MEM_WAIT;
    end else if (ex_branch_taken) begin
      run_ctrl = CTRL_FLUSH;
    end else if (lu) begin
      run_ctrl = CTRL_STALL;
      if (LU_STALL_CYCLES > 1) begin
        run_next    = LU_STALL;
        run_lu_left = LU_LEFT_INIT;
      end
    end
  end

  always_comb begin
    ctrl         = CTRL_DEFAULT;
    next_state   = state_q;
    next_lu_left = lu_left_q;
    case (state_q)
      LU_STALL: begin
        if (mem_busy) begin
          ctrl       = CTRL_FREEZE;
          next_state = MEM_WAIT;
        end else begin
          ctrl         = CTRL_STALL;
          next_lu_left = (lu_left_q != 2'd0) ? lu_left_q - 2'd1 : 2'd0;
          next_state   = (lu_left_q <= 2'd1) ? RUN : LU_STALL;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl = run_ctrl;
          // An interrupted load-use stall resumes with its remaining count
          if (lu_left_q != 2'd0) begin
            next_state = LU_STALL;
          end else begin
            next_state   = run_next;
            next_lu_left = run_lu_left;
          end
        end
      end
      default: begin
        ctrl         = run_ctrl;
        next_state   = run_next;
        next_lu_left = run_lu_left;
      end
    endcase
    if (rst) begin
      ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      lu_left_q <= 2'd0;
    end else begin
      state_q   <= next_state;
      lu_left_q <= next_lu_left;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign idex_hold   = ctrl.idex_hold;
  assign exmem_hold  = ctrl.exmem_hold;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  // Outside reset, ifid_flush is raised only by a taken branch
  logic stall_inc, flush_inc;
  assign stall_inc = !rst && !ctrl.pc_write;
  assign flush_inc = !rst && ctrl.ifid_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with LU_STALL_CYCLES 1, 2
// and 3 share one stimulus stream; the third uses a 2-bit counter to hit saturation.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] DEF    = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] FREEZE = 6'b000011;
  localparam logic [5:0] FLUSH  = 6'b101100;
  localparam logic [5:0] RSTV   = 6'b001100;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memRead, ex_branch_taken, mem_busy;

  logic [5:0]  ctl1, ctl2, ctl3;
  logic [1:0]  st1, st2, st3;
  logic [31:0] sc1, fc1, sc2, fc2;
  logic [1:0]  sc3, fc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(ctl1[5]), .ifid_write(ctl1[4]), .ifid_flush(ctl1[3]),
    .idex_bubble(ctl1[2]), .idex_hold(ctl1[1]), .exmem_hold(ctl1[0]),
    .state_o(st1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(ctl2[5]), .ifid_write(ctl2[4]), .ifid_flush(ctl2[3]),
    .idex_bubble(ctl2[2]), .idex_hold(ctl2[1]), .exmem_hold(ctl2[0]),
    .state_o(st2), .stall_cnt(sc2), .flush_cnt(fc2));

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(ctl3[5]), .ifid_write(ctl3[4]), .ifid_flush(ctl3[3]),
    .idex_bubble(ctl3[2]), .idex_hold(ctl3[1]), .exmem_hold(ctl3[0]),
    .state_o(st3), .stall_cnt(sc3), .flush_cnt(fc3));

  // Counter values are only meaningful when the counters are built in
  function automatic logic [31:0] cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic bt, input logic mb,
                               input logic r);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memRead = mr; ex_rd = rd; ex_branch_taken = bt; mem_busy = mb; rst = r;
    #2;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_ctl1", 32'(ctl1), 32'(RSTV));
    checkOutput("rst_ctl3", 32'(ctl3), 32'(RSTV));
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; ex_memRead = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

    // Reset state
    doReset();
    idle();
    checkOutput("post_rst_ctl1", 32'(ctl1), 32'(DEF));
    checkOutput("post_rst_st2", 32'(st2), 32'd0);
    checkOutput("post_rst_sc1", sc1, cnt(0));
    checkOutput("post_rst_fc1", fc1, cnt(0));

    // Load-use on rs1, then bubbles in EX
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ctl1", 32'(ctl1), 32'(STALL));
    checkOutput("lu_ctl2", 32'(ctl2), 32'(STALL));
    checkOutput("lu_ctl3", 32'(ctl3), 32'(STALL));
    checkOutput("lu_st2", 32'(st2), 32'd0);
    idle();
    checkOutput("lu1_ctl1", 32'(ctl1), 32'(DEF));
    checkOutput("lu1_sc1", sc1, cnt(1));
    checkOutput("lu1_ctl2", 32'(ctl2), 32'(STALL));
    checkOutput("lu1_st2", 32'(st2), 32'd1);
    checkOutput("lu1_st3", 32'(st3), 32'd1);
    idle();
    checkOutput("lu2_ctl2", 32'(ctl2), 32'(DEF));
    checkOutput("lu2_st2", 32'(st2), 32'd0);
    checkOutput("lu2_ctl3", 32'(ctl3), 32'(STALL));
    checkOutput("lu2_st3", 32'(st3), 32'd1);
    idle();
    checkOutput("lu3_ctl3", 32'(ctl3), 32'(DEF));
    checkOutput("lu3_st3", 32'(st3), 32'd0);
    checkOutput("lu3_sc2", sc2, cnt(2));
    checkOutput("lu3_sc3", 32'(sc3), cnt(3));

    // ex_rd = 0 never stalls; rs2 counts only when used
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rd0_ctl1", 32'(ctl1), 32'(DEF));
    checkOutput("rd0_ctl2", 32'(ctl2), 32'(DEF));
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_unused_ctl1", 32'(ctl1), 32'(DEF));
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_used_ctl1", 32'(ctl1), 32'(STALL));

    // Taken branch beats a simultaneous load-use
    doReset();
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("br_ctl1", 32'(ctl1), 32'(FLUSH));
    checkOutput("br_ctl3", 32'(ctl3), 32'(FLUSH));
    idle();
    checkOutput("br_st3", 32'(st3), 32'd0);
    checkOutput("br_ctl1_next", 32'(ctl1), 32'(DEF));
    checkOutput("br_fc1", fc1, cnt(1));
    checkOutput("br_sc1", sc1, cnt(0));

    // Memory busy for three cycles in RUN
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("mb_ctl1_%0d", i), 32'(ctl1), 32'(FREEZE));
      checkOutput($sformatf("mb_st1_%0d", i), 32'(st1), (i == 0) ? 32'd0 : 32'd2);
    end
    idle();
    checkOutput("mb_exit_ctl1", 32'(ctl1), 32'(DEF));
    checkOutput("mb_exit_st1", 32'(st1), 32'd2);
    checkOutput("mb_sc1", sc1, cnt(3));
    idle();
    checkOutput("mb_after_st1", 32'(st1), 32'd0);

    // Memory busy arrives on the first LU_STALL cycle
    doReset();
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lumb_c1_ctl3", 32'(ctl3), 32'(STALL));
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lumb_c2_ctl3", 32'(ctl3), 32'(FREEZE));
    checkOutput("lumb_c2_st3", 32'(st3), 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lumb_c3_ctl3", 32'(ctl3), 32'(FREEZE));
    checkOutput("lumb_c3_st3", 32'(st3), 32'd2);
    idle();
    checkOutput("lumb_c4_ctl3", 32'(ctl3), 32'(DEF));
    checkOutput("lumb_c4_st3", 32'(st3), 32'd2);
    idle();
    checkOutput("lumb_c5_ctl3", 32'(ctl3), 32'(STALL));
    checkOutput("lumb_c5_st3", 32'(st3), 32'd1);
    checkOutput("lumb_c5_ctl2", 32'(ctl2), 32'(STALL));
    checkOutput("lumb_c5_ctl1", 32'(ctl1), 32'(DEF));
    idle();
    checkOutput("lumb_c6_ctl3", 32'(ctl3), 32'(STALL));
    checkOutput("lumb_c6_ctl2", 32'(ctl2), 32'(DEF));
    checkOutput("lumb_c6_st2", 32'(st2), 32'd0);
    idle();
    checkOutput("lumb_c7_ctl3", 32'(ctl3), 32'(DEF));
    checkOutput("lumb_c7_st3", 32'(st3), 32'd0);
    checkOutput("lumb_sc1", sc1, cnt(3));
    checkOutput("lumb_sc2", sc2, cnt(4));
    checkOutput("lumb_sc3_sat", 32'(sc3), cnt(3));

    // Reset while waiting on memory
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rstmw_freeze", 32'(ctl1), 32'(FREEZE));
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("rstmw_ctl1", 32'(ctl1), 32'(RSTV));
    checkOutput("rstmw_st1", 32'(st1), 32'd2);
    idle();
    checkOutput("rstmw_after_st1", 32'(st1), 32'd0);
    checkOutput("rstmw_after_ctl1", 32'(ctl1), 32'(DEF));
    checkOutput("rstmw_after_sc1", sc1, cnt(0));

    // Flush counter saturation on the 2-bit instance
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("brs_ctl3_%0d", i), 32'(ctl3), 32'(FLUSH));
    end
    idle();
    checkOutput("brs_fc1", fc1, cnt(4));
    checkOutput("brs_fc3_sat", 32'(fc3), cnt(3));
    checkOutput("brs_sc3", 32'(sc3), cnt(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard controller. It consumes the ID/EX stage outputs (memRead, destination register from the latched instruction, branch resolution in EX) and drives the write-enable, flush, bubble and hold controls back into PC, IF/ID and ID/EX.
- Handles load-use stalls (multi-cycle, parameterised), taken-branch flushes and whole-pipeline freeze on a busy data memory.
- Mealy controller: controls are combinational from the registered FSM state plus current inputs. Performance counters are optional.

Parameters:
- REG_ADDR_W, 5, register index width.
- LU_STALL_CYCLES, 1, bubbles per load-use hazard (1..3). Use 2 when MEM->EX forwarding is absent.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
- id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_memRead  in  1  memRead_o from ID/EX (load in EX)
- ex_rd  in  REG_ADDR_W  inst_o[11:7] from ID/EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_bubble  out  1  ID/EX loads all-zero controls (NOP)
- idex_hold  out  1  ID/EX keeps current contents
- exmem_hold  out  1  EX/MEM and MEM/WB keep contents
- state_o  out  2  current FSM state (debug)
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Load-use hazard (lu): ex_memRead & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2. 3 is unused and maps to RUN. Down-counter lu_left has width 2.
- Default outputs: pc_write=1, ifid_write=1, all flush/bubble/hold outputs 0.
- RUN, priority mem_busy > ex_branch_taken > lu:
  - mem_busy: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1. Next state MEM_WAIT.
  - branch taken: ifid_flush=1, idex_bubble=1, pc_write=1. Stay in RUN. Any lu in the same cycle is discarded because the ID instruction is flushed.
  - lu: pc_write=0, ifid_write=0, idex_bubble=1. If LU_STALL_CYCLES>1, next state LU_STALL and lu_left=LU_STALL_CYCLES-1.
- LU_STALL:
  - If mem_busy: same freeze as RUN, next state MEM_WAIT, lu_left retained.
  - Otherwise: pc_write=0, ifid_write=0, idex_bubble=1, lu_left decrements. When lu_left==1 in this cycle, next state RUN.
  - ex_branch_taken cannot occur here because EX holds a bubble; if asserted it is ignored.
- MEM_WAIT:
  - While mem_busy=1: full freeze as above.
  - On the first cycle with mem_busy=0: evaluate the RUN rules combinationally in that same cycle (zero-cycle exit), then move to RUN, or to LU_STALL if lu_left!=0.
- Freeze outputs are asserted in the same cycle as mem_busy, with no added latency.
- Reset:
  - While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, idex_hold=0, exmem_hold=0.
  - On the next edge: state=RUN, lu_left=0, counters=0. Reset mid-stall or mid-wait abandons the state unconditionally.
- Counters saturate at all-ones and never wrap:
  - stall_cnt increments every non-reset cycle with pc_write=0.
  - flush_cnt increments on each cycle with ifid_flush=1 caused by a branch.

Optional Feature:
- HAZARD_PERF_CNT_EN
  - Defined: stall_cnt and flush_cnt are implemented as above.
  - Undefined: counter logic is removed and both ports are tied to 0. FSM and control outputs are identical in both builds.

Decomposition:
- Package hazard_pkg: state enum (RUN, LU_STALL, MEM_WAIT), REG_ADDR_W, NOP control constants.
- Sub-module sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated twice under the macro.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LU_STALL_CYCLES=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle all defaults; stall_cnt=1.
- LU_STALL_CYCLES=2, same hazard -> two consecutive stall cycles, state_o 0->1->0; ex_rd=0 with the same stimulus -> no stall.
- Branch taken together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall; flush_cnt=1.
- mem_busy high for 3 cycles in RUN -> idex_hold=exmem_hold=1 and pc_write=0 for exactly those 3 cycles; 4th cycle defaults, state back to RUN; stall_cnt=3.
- mem_busy asserted during LU_STALL (CYCLES=3, first stall cycle) -> MEM_WAIT, then remaining 2 stall cycles resume after mem_busy drops.
- rst asserted mid MEM_WAIT -> reset output values that cycle; state_o=0 and counters=0 after the edge. Without HAZARD_PERF_CNT_EN, counters read 0 throughout all scenarios.
